// File: rtl/cv32e40p_obi_pkg.sv
// Shared OBI widths and A-channel bundle for the LSU/prefetch OBI path.
package cv32e40p_obi_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_BE_W   = 4;

  typedef struct packed {
    logic [OBI_ADDR_W-1:0] addr;
    logic                  we;
    logic [OBI_BE_W-1:0]   be;
    logic [OBI_DATA_W-1:0] wdata;
  } obi_a_chan_t;

endpackage

// File: rtl/cv32e40p_obi_tag_fifo.sv
// In-order DEPTH x TAG_W tag buffer for outstanding OBI transactions.
// With CV32E40P_OBI_TRACKER_KILL_EN each entry carries a drop bit.
module cv32e40p_obi_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
  input  logic             i_kill,
  output logic             o_head_drop,
`endif
  input  logic             i_push,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_pop,
  output logic [TAG_W-1:0] o_head_tag,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [TAG_W-1:0] r_tag [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
  logic             r_valid [DEPTH];
  logic             r_drop  [DEPTH];
`endif

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full     = (r_cnt == CNT_W'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_cnt      = r_cnt;
  assign o_head_tag = o_empty ? '0 : r_tag[r_rd_ptr];
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
  assign o_head_drop = !o_empty && r_drop[r_rd_ptr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      // NOTE: tag storage is reset on purpose so a stale tag can never leak out after reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
        r_valid[i] <= 1'b0;
        r_drop[i]  <= 1'b0;
`endif
      end
    end else begin
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
      if (i_kill) begin
        for (int i = 0; i < DEPTH; i++) r_drop[i] <= r_drop[i] | r_valid[i];
      end
`endif
      if (w_push) begin
        r_tag[r_wr_ptr] <= i_tag;
        r_wr_ptr        <= f_next(r_wr_ptr);
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
        r_valid[r_wr_ptr] <= 1'b1;
        r_drop[r_wr_ptr]  <= 1'b0;
`endif
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
        r_valid[r_rd_ptr] <= 1'b0;
        r_drop[r_rd_ptr]  <= 1'b0;
`endif
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_obi_req_tracker.sv
// Outstanding-transaction limiter and in-order tag tracker in front of the OBI adapter.
// Optional kill support is enabled with CV32E40P_OBI_TRACKER_KILL_EN.
module cv32e40p_obi_req_tracker
  import cv32e40p_obi_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
  input  logic                         kill_i,
`endif
  input  logic                         core_req_i,
  output logic                         core_gnt_o,
  input  logic [OBI_ADDR_W-1:0]        core_addr_i,
  input  logic                         core_we_i,
  input  logic [OBI_BE_W-1:0]          core_be_i,
  input  logic [OBI_DATA_W-1:0]        core_wdata_i,
  input  logic [TAG_W-1:0]             core_tag_i,
  output logic                         trans_valid_o,
  input  logic                         trans_ready_i,
  output logic [OBI_ADDR_W-1:0]        trans_addr_o,
  output logic                         trans_we_o,
  output logic [OBI_BE_W-1:0]          trans_be_o,
  output logic [OBI_DATA_W-1:0]        trans_wdata_o,
  input  logic                         resp_valid_i,
  input  logic [OBI_DATA_W-1:0]        resp_rdata_i,
  input  logic                         resp_err_i,
  output logic                         core_rvalid_o,
  output logic [OBI_DATA_W-1:0]        core_rdata_o,
  output logic                         core_err_o,
  output logic [TAG_W-1:0]             core_rtag_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
  output logic                         busy_o,
  output logic                         unexp_resp_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  obi_a_chan_t      w_a_chan;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt;
  logic             r_unexp;
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
  logic             w_head_drop;
`endif

  assign w_a_chan = '{addr: core_addr_i, we: core_we_i, be: core_be_i, wdata: core_wdata_i};
  assign trans_addr_o  = w_a_chan.addr;
  assign trans_we_o    = w_a_chan.we;
  assign trans_be_o    = w_a_chan.be;
  assign trans_wdata_o = w_a_chan.wdata;

  // NOTE: gating uses registered fullness only; a response frees a slot for the next cycle.
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
  assign trans_valid_o = core_req_i && !w_full && !kill_i;
`else
  assign trans_valid_o = core_req_i && !w_full;
`endif
  assign core_gnt_o = trans_valid_o && trans_ready_i;

  assign w_pop = resp_valid_i && !w_empty;
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
  assign core_rvalid_o = w_pop && !w_head_drop;
`else
  assign core_rvalid_o = w_pop;
`endif
  assign core_rdata_o = resp_rdata_i;
  assign core_err_o   = resp_err_i;
  assign cnt_o        = w_cnt;
  assign busy_o       = !w_empty;
  assign unexp_resp_o = r_unexp;

  cv32e40p_obi_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
    .i_kill      (kill_i),
    .o_head_drop (w_head_drop),
`endif
    .i_push      (core_gnt_o),
    .i_tag       (core_tag_i),
    .i_pop       (w_pop),
    .o_head_tag  (core_rtag_o),
    .o_cnt       (w_cnt),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_unexp <= 1'b0;
    else        r_unexp <= r_unexp | (resp_valid_i && w_empty);
  end

endmodule

// File: tb/tb_cv32e40p_obi_req_tracker.sv
// Directed scoreboard bench for cv32e40p_obi_req_tracker (DEPTH=2, TAG_W=8).
module tb_cv32e40p_obi_req_tracker;

  localparam int DEPTH = 2;
  localparam int TAG_W = 8;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      rdata;
    logic             err;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              core_req_i;
  logic              core_gnt_o;
  logic [31:0]       core_addr_i;
  logic              core_we_i;
  logic [3:0]        core_be_i;
  logic [31:0]       core_wdata_i;
  logic [TAG_W-1:0]  core_tag_i;
  logic              trans_valid_o;
  logic              trans_ready_i;
  logic [31:0]       trans_addr_o;
  logic              trans_we_o;
  logic [3:0]        trans_be_o;
  logic [31:0]       trans_wdata_o;
  logic              resp_valid_i;
  logic [31:0]       resp_rdata_i;
  logic              resp_err_i;
  logic              core_rvalid_o;
  logic [31:0]       core_rdata_o;
  logic              core_err_o;
  logic [TAG_W-1:0]  core_rtag_o;
  logic [1:0]        cnt_o;
  logic              busy_o;
  logic              unexp_resp_o;
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
  logic              kill_i;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cv32e40p_obi_req_tracker #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
    .kill_i        (kill_i),
`endif
    .core_req_i    (core_req_i),
    .core_gnt_o    (core_gnt_o),
    .core_addr_i   (core_addr_i),
    .core_we_i     (core_we_i),
    .core_be_i     (core_be_i),
    .core_wdata_i  (core_wdata_i),
    .core_tag_i    (core_tag_i),
    .trans_valid_o (trans_valid_o),
    .trans_ready_i (trans_ready_i),
    .trans_addr_o  (trans_addr_o),
    .trans_we_o    (trans_we_o),
    .trans_be_o    (trans_be_o),
    .trans_wdata_o (trans_wdata_o),
    .resp_valid_i  (resp_valid_i),
    .resp_rdata_i  (resp_rdata_i),
    .resp_err_i    (resp_err_i),
    .core_rvalid_o (core_rvalid_o),
    .core_rdata_o  (core_rdata_o),
    .core_err_o    (core_err_o),
    .core_rtag_o   (core_rtag_o),
    .cnt_o         (cnt_o),
    .busy_o        (busy_o),
    .unexp_resp_o  (unexp_resp_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; a delivered response queues its expected tag/data.
  task automatic drive(input logic req, input logic [7:0] tag, input logic rv,
                       input logic [7:0] exp_tag, input logic [31:0] rdata, input logic err);
    core_req_i   = req;
    core_tag_i   = tag;
    core_addr_i  = 32'h1000_0000 | {24'h0, tag};
    core_we_i    = tag[0];
    core_be_i    = tag[3:0];
    core_wdata_i = 32'hCAFE_0000 | {24'h0, tag};
    resp_valid_i = rv;
    resp_rdata_i = rdata;
    resp_err_i   = err;
    if (rv && (exp_tag != 8'h00)) exp_q.push_back('{tag: exp_tag, rdata: rdata, err: err});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every delivered response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && core_rvalid_o) begin
      if (exp_q.size() == 0) begin
        check("rvalid_without_expectation", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rtag", {24'h0, core_rtag_o}, {24'h0, e.tag});
        check("rdata", core_rdata_o, e.rdata);
        check("rerr", {31'h0, core_err_o}, {31'h0, e.err});
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    trans_ready_i = 1'b1;
`ifdef CV32E40P_OBI_TRACKER_KILL_EN
    kill_i        = 1'b0;
`endif
    drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("reset_cnt", cnt_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_unexp", unexp_resp_o, 0);
    check("reset_trans_valid", trans_valid_o, 0);
    tick();
    rst_n = 1'b1;

    // Three back-to-back requests into DEPTH=2, no responses.
    drive(1'b1, 8'h11, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("gnt_req1", core_gnt_o, 1);
    check("addr_pass", trans_addr_o, 32'h1000_0011);
    check("wdata_pass", trans_wdata_o, 32'hCAFE_0011);
    check("we_be_pass", {27'h0, trans_we_o, trans_be_o}, {27'h0, 1'b1, 4'h1});
    tick();
    drive(1'b1, 8'h22, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("gnt_req2", core_gnt_o, 1);
    check("cnt_after1", cnt_o, 1);
    tick();
    drive(1'b1, 8'h33, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("gnt_req3_full", core_gnt_o, 0);
    check("tvalid_full", trans_valid_o, 0);
    check("cnt_full", cnt_o, 2);
    check("busy_full", busy_o, 1);
    tick();

    // Response frees a slot only from the next cycle.
    drive(1'b1, 8'h33, 1'b1, 8'h11, 32'hA000_0001, 1'b0);
    @(negedge clk);
    check("rvalid_resp1", core_rvalid_o, 1);
    check("gnt_same_cycle_as_resp", core_gnt_o, 0);
    tick();
    drive(1'b1, 8'h33, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("gnt_req3_after_free", core_gnt_o, 1);
    check("cnt_after_free", cnt_o, 1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 8'h22, 32'hA000_0002, 1'b1);
    @(negedge clk);
    check("cnt_before_resp2", cnt_o, 2);
    tick();

    // Push and pop together at cnt=1.
    drive(1'b1, 8'h44, 1'b1, 8'h33, 32'hA000_0003, 1'b0);
    @(negedge clk);
    check("gnt_push_pop", core_gnt_o, 1);
    check("cnt_push_pop_before", cnt_o, 1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("cnt_push_pop_after", cnt_o, 1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 8'h44, 32'hA000_0004, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("cnt_drained", cnt_o, 0);
    check("busy_drained", busy_o, 0);
    check("unexp_still_clear", unexp_resp_o, 0);
    tick();

    // Unexpected response while empty.
    drive(1'b0, 8'h00, 1'b1, 8'h00, 32'hDEAD_0000, 1'b0);
    @(negedge clk);
    check("rvalid_unexp", core_rvalid_o, 0);
    check("rtag_empty_zero", core_rtag_o, 0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("unexp_set", unexp_resp_o, 1);
    check("cnt_after_unexp", cnt_o, 0);
    tick();

    // Response in the grant cycle while empty: no pop, entry still counted.
    drive(1'b1, 8'h55, 1'b1, 8'h00, 32'hDEAD_0001, 1'b0);
    @(negedge clk);
    check("gnt_with_unexp", core_gnt_o, 1);
    check("rvalid_grant_cycle", core_rvalid_o, 0);
    tick();
    drive(1'b1, 8'h66, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("cnt_grant_cycle_resp", cnt_o, 1);
    check("unexp_sticky", unexp_resp_o, 1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("cnt_before_reset", cnt_o, 2);
    tick();

    // Asynchronous reset mid-stream.
    rst_n = 1'b0;
    #2;
    check("midreset_cnt", cnt_o, 0);
    check("midreset_busy", busy_o, 0);
    check("midreset_unexp", unexp_resp_o, 0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 8'h77, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("gnt_after_reset", core_gnt_o, 1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 8'h77, 32'hB000_0077, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("cnt_after_reset_pair", cnt_o, 0);
    tick();

`ifdef CV32E40P_OBI_TRACKER_KILL_EN
    drive(1'b1, 8'h81, 1'b0, 8'h00, 32'h0, 1'b0);
    tick();
    drive(1'b1, 8'h82, 1'b0, 8'h00, 32'h0, 1'b0);
    tick();
    drive(1'b1, 8'h83, 1'b0, 8'h00, 32'h0, 1'b0);
    kill_i = 1'b1;
    @(negedge clk);
    check("kill_tvalid", trans_valid_o, 0);
    check("kill_cnt", cnt_o, 2);
    tick();
    kill_i = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 8'h00, 32'hE000_0001, 1'b0);
    @(negedge clk);
    check("kill_rvalid1", core_rvalid_o, 0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 8'h00, 32'hE000_0002, 1'b0);
    @(negedge clk);
    check("kill_cnt1", cnt_o, 1);
    check("kill_rvalid2", core_rvalid_o, 0);
    tick();
    drive(1'b1, 8'h84, 1'b0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    check("kill_cnt0", cnt_o, 0);
    check("kill_gnt_after", core_gnt_o, 1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 8'h84, 32'hE000_0084, 1'b0);
    @(negedge clk);
    check("kill_rvalid_after", core_rvalid_o, 1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 1'b0);
    tick();
`endif

    @(negedge clk);
    check("all_responses_delivered", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
